// File: rtl/sad_stream_gen.sv
// sad_stream_gen: accumulates the 16x16 SAD of each search candidate from
// streamed pixel rows and emits (valid, addr, amt, sad) in raster order.
module sad_stream_gen #(
    parameter int SRCH_W = 32,
    parameter int SRCH_H = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] cur_row,
    input  logic [127:0] ref_row,
    input  logic         row_valid,
    output logic         row_ready,
    output logic         valid,
    output logic [5:0]   addr,
    output logic [5:0]   amt,
    output logic [15:0]  sad,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0]  row_cnt;
    logic [5:0]  x_cnt;
    logic [5:0]  y_cnt;
    logic [15:0] acc;
    logic [11:0] row_sum;
    logic [15:0] acc_sum;
    logic        accept;
    logic        last_row;
    logic        last_x;
    logic        last_y;

    logic signed [8:0] diff [16];
    logic        [8:0] mag  [16];

    assign accept   = row_valid && (state == RUN);
    assign last_row = (row_cnt == 4'd15);
    assign last_x   = (x_cnt == 6'(SRCH_W - 1));
    assign last_y   = (y_cnt == 6'(SRCH_H - 1));

    // First row of a candidate restarts the running sum.
    assign acc_sum = ((row_cnt == 4'd0) ? 16'd0 : acc) + {4'd0, row_sum};

    // Row SAD: sum of 16 absolute 9-bit signed pixel differences.
    always_comb begin
        row_sum = '0;
        for (int i = 0; i < 16; i++) begin
            diff[i] = $signed({1'b0, cur_row[8*i +: 8]})
                    - $signed({1'b0, ref_row[8*i +: 8]});
            mag[i]  = diff[i][8] ? 9'(-diff[i]) : 9'(diff[i]);
            row_sum = row_sum + 12'(mag[i]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_nx  = state;
        row_ready = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                row_ready = 1'b1;
                busy      = 1'b1;
                if (accept && last_row && last_x && last_y) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Counters, accumulator and the registered result tuple.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            acc     <= '0;
            valid   <= 1'b0;
            done    <= 1'b0;
            sad     <= '0;
            addr    <= '0;
            amt     <= '0;
        end else begin
            valid <= 1'b0;
            done  <= (state == FLUSH);
            if (state == IDLE && start) begin
                row_cnt <= '0;
                x_cnt   <= '0;
                y_cnt   <= '0;
                acc     <= '0;
            end else if (accept) begin
                acc     <= acc_sum;
                row_cnt <= row_cnt + 4'd1;
                if (last_row) begin
                    valid <= 1'b1;
                    sad   <= acc_sum;
                    addr  <= x_cnt;
                    amt   <= y_cnt;
                    if (last_x) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + 6'd1;
                    end else begin
                        x_cnt <= x_cnt + 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_stream_gen.sv
// tb_sad_stream_gen: directed scans of a 2x2 window with random pixel data,
// checked against a plain-arithmetic SAD model.
module tb_sad_stream_gen;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int NC = W * H;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] cur_row;
    logic [127:0] ref_row;
    logic         row_valid;
    logic         row_ready;
    logic         valid;
    logic [5:0]   addr;
    logic [5:0]   amt;
    logic [15:0]  sad;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [127:0] cm [NC][16];
    logic [127:0] rm [NC][16];
    logic [27:0]  obs_q [$];

    sad_stream_gen #(.SRCH_W(W), .SRCH_H(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cur_row(cur_row), .ref_row(ref_row),
        .row_valid(row_valid), .row_ready(row_ready),
        .valid(valid), .addr(addr), .amt(amt), .sad(sad),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Collect every result tuple the comparator would see.
    always @(negedge clk) begin
        if (valid === 1'b1) obs_q.push_back({sad, addr, amt});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_sad(input int c);
        int s = 0;
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 16; i++) begin
                int a = int'(cm[c][r][8*i +: 8]);
                int b = int'(rm[c][r][8*i +: 8]);
                s += (a > b) ? a - b : b - a;
            end
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] splat(input logic [7:0] p);
        return {16{p}};
    endfunction

    // kind 0: all zero; kind 1: extremes + both-sign pattern; kind 2: random
    task automatic fill(input int kind);
        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < 16; r++) begin
                if (kind == 0) begin
                    cm[c][r] = '0;
                    rm[c][r] = '0;
                end else if (kind == 1 && c == 0) begin
                    cm[c][r] = splat(8'hFF);
                    rm[c][r] = splat(8'h00);
                end else if (kind == 1 && c == 1) begin
                    cm[c][r] = splat(r < 8 ? 8'h10 : 8'h30);
                    rm[c][r] = splat(r < 8 ? 8'h30 : 8'h10);
                end else begin
                    cm[c][r] = rnd128();
                    rm[c][r] = rnd128();
                end
            end
        end
    endtask

    task automatic send_row(input logic [127:0] c, input logic [127:0] r,
                            input bit stall, input bit pulse);
        int g = 0;
        bit sent = 0;
        while (!sent) begin
            @(negedge clk);
            start = 1'b0;
            chk("row_ready_run", row_ready, 1);
            if (stall && $urandom_range(1, 0) == 1) begin
                row_valid = 1'b0;
            end else begin
                row_valid = 1'b1;
                cur_row   = c;
                ref_row   = r;
                start     = pulse;
                sent      = 1;
            end
            g++;
            if (!sent && g > 60) begin
                checks++;
                errors++;
                $error("FAIL stall_bound observed %0d expected <=60", g);
                sent = 1;
            end
        end
    endtask

    task automatic run_scan(input bit stall, input bit do_start,
                            input bit chain, input bit mid, input bit kind1);
        int base = obs_q.size();
        logic [27:0] e;
        if (do_start) begin
            @(negedge clk);
            start = 1'b1;
            row_valid = 1'b0;
            @(negedge clk);
            start = 1'b0;
            chk("busy_after_start", busy, 1);
        end
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < 16; r++)
                send_row(cm[c][r], rm[c][r], stall, mid && c == 1 && r == 3);
        @(negedge clk);
        start = 1'b0;
        row_valid = 1'b0;
        chk("flush_valid", valid, 1);
        chk("flush_done", done, 0);
        chk("flush_busy", busy, 1);
        chk("flush_ready", row_ready, 0);
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_valid", valid, 0);
        chk("done_busy", busy, 0);
        if (chain) start = 1'b1;
        chk("valid_count", obs_q.size() - base, NC);
        for (int k = 0; k < NC && base + k < obs_q.size(); k++) begin
            e = obs_q[base + k];
            chk("sad", e[27:12], exp_sad(k));
            chk("addr", e[11:6], k % W);
            chk("amt", e[5:0], k / W);
        end
        if (kind1 && obs_q.size() >= base + 2) begin
            e = obs_q[base];
            chk("sad_ff00", e[27:12], 16'hFF00);
            e = obs_q[base + 1];
            chk("sad_8192", e[27:12], 8192);
        end
    endtask

    initial begin
        int base;
        logic [27:0] e;
        rst = 1'b1;
        start = 1'b0;
        row_valid = 1'b0;
        cur_row = '0;
        ref_row = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", row_ready, 0);
        chk("rst_sad", sad, 0);
        chk("rst_addr", addr, 0);
        chk("rst_amt", amt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", row_ready, 0);

        fill(0);
        run_scan(0, 1, 0, 0, 0);
        fill(1);
        run_scan(0, 1, 0, 0, 1);
        fill(2);
        run_scan(0, 1, 0, 0, 0);
        run_scan(1, 1, 0, 0, 0);

        // abandon candidate (1,0) after 10 rows
        fill(2);
        base = obs_q.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 16; r++) send_row(cm[0][r], rm[0][r], 0, 0);
        for (int r = 0; r < 10; r++) send_row(cm[1][r], rm[1][r], 0, 0);
        @(negedge clk);
        row_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_addr", addr, 0);
        chk("abort_amt", amt, 0);
        chk("abort_sad", sad, 0);
        chk("abort_ready", row_ready, 0);
        repeat (3) @(negedge clk);
        chk("abort_count", obs_q.size() - base, 1);
        if (obs_q.size() > base) begin
            e = obs_q[base];
            chk("abort_c0_sad", e[27:12], exp_sad(0));
        end

        // fresh scan with an ignored mid-scan start, restarted in done cycle
        fill(1);
        run_scan(0, 1, 1, 1, 1);
        fill(2);
        run_scan(1, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sad_stream_gen.md
Name: sad_stream_gen

Overview:
- Motion-estimation SAD producer feeding the minimum-SAD comparator in the inter-prediction path.
- Accepts current-MB and reference-candidate pixel rows over a valid/ready stream and accumulates the 16x16 sum of absolute differences per candidate.
- Walks the search window in raster order and emits one (valid, addr, amt, sad) tuple per candidate, in the exact form the comparator consumes.
- Signals done after the last candidate.

Parameters:
- SRCH_W, 32, candidate columns per search row (1..64); drives addr.
- SRCH_H, 32, candidate rows per search window (1..64); drives amt.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begins a window scan from IDLE
- cur_row  in  128  16 current-MB pixels, pixel i at bits [8i+7:8i], unsigned
- ref_row  in  128  16 reference pixels for the same row of the current candidate
- row_valid  in  1  cur_row/ref_row valid
- row_ready  out  1  block accepts a row this cycle
- valid  out  1  one-cycle pulse; sad/addr/amt hold a finished candidate
- addr  out  6  candidate x index (column)
- amt  out  6  candidate y index (row)
- sad  out  16  16x16 SAD of the candidate
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after the final candidate's valid

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: valid=0, done=0, busy=0, row_ready=0, sad=0, addr=0, amt=0. The FSM goes to IDLE and all counters and the accumulator clear.
- Reset mid-scan: the scan is abandoned; the next cycle is IDLE with all outputs at reset values. No valid is emitted for a partial candidate.
- FSM state IDLE:
  - row_ready=0.
  - start moves to RUN and clears row_cnt (4b), x_cnt, y_cnt and the accumulator.
- FSM state RUN:
  - row_ready=1, busy=1.
  - A beat is accepted when row_valid && row_ready.
  - A row_valid low cycle stalls the scan without losing state.
- FSM state FLUSH:
  - Entered after the last beat of the last candidate. row_ready=0.
  - Lasts one cycle, in which that candidate's valid is high. done=1 is asserted on the following cycle together with the return to IDLE.
- Arithmetic:
  - row_sum = sum over i of |cur_i - ref_i|, computed on 9-bit signed differences; 12-bit result, max 4080.
  - acc = (row_cnt==0 ? 0 : acc) + row_sum. Max 16*4080 = 65280, so 16 bits, no saturation.
- Candidate completion (beat with row_cnt==15 accepted):
  - Next cycle: valid=1, sad=acc+row_sum, addr=x_cnt, amt=y_cnt for the candidate just finished.
  - Outputs hold between pulses; valid is high for exactly one cycle.
  - Latency from last-row accept to valid is 1 cycle.
- Counter advance on that same accept:
  - row_cnt wraps to 0.
  - x_cnt increments. At x_cnt==SRCH_W-1 it wraps to 0 and y_cnt increments.
  - At x_cnt==SRCH_W-1 and y_cnt==SRCH_H-1, go to FLUSH.
- Back-to-back candidates: the next candidate's first row may be accepted in the same cycle the previous valid is high. Sustained throughput is one candidate per 16 cycles.
- No downstream backpressure: the comparator always accepts valid.
- start in RUN or FLUSH is ignored. start in the done cycle (IDLE) begins a new scan.
- busy is high from the cycle after start through the FLUSH cycle.

Test Plan:
- Reset, then start with SRCH_W=SRCH_H=2; all 64 rows cur=ref=0x00 -> four valid pulses with sad=0 at (addr,amt)=(0,0),(1,0),(0,1),(1,1); done one cycle after the 4th valid.
- One candidate with every cur pixel 0xFF and every ref pixel 0x00 -> sad=65280 (0xFF00), no overflow.
- cur=0x10 and ref=0x30 on rows 0-7, cur=0x30 and ref=0x10 on rows 8-15 -> sad=256*32=8192; exercises the absolute value in both directions.
- row_valid toggled randomly at 50% during a 2x2 scan -> identical sad/addr/amt sequence to the stall-free run; row_ready stays 1 in RUN.
- Assert rst after 10 rows of candidate (1,0) -> next cycle busy=0, valid=0, addr=amt=0. A fresh start then produces (0,0) first.
- start pulsed mid-scan and again in the done cycle -> the mid-scan pulse is ignored; the done-cycle pulse starts a second full scan with valid count = SRCH_W*SRCH_H.
